// File: rtl/uart_link_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, level go/ack handshake.
// state     | meaning
// RX_IDLE   | armed, waiting for a synced low on the line
// RX_START  | half-bit wait, then confirm the start bit (high = glitch)
// RX_DATA   | sample 8 data bits mid-bit, LSB first
// RX_STOP   | mid stop-bit sample, raise rx_data_ready
// RX_WAIT_ACK | byte held until rx_go drops
// RX_WAIT_GO  | wait for re-arm with an idle line
module uart_link_rx #(
    parameter int BitTime = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       rx_go,
    output logic [7:0] rx_data,
    output logic       rx_data_ready
);
    localparam int CW = $clog2(BitTime + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BitTime - 1);
    // The cycle that first sees the synced low counts toward the half bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(BitTime / 2 - 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_ACK, RX_WAIT_GO
    } rx_state_t;

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ready_d = ready_q;
        case (state_q)
            RX_IDLE: begin
                if (rx_go && !rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_sync) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = BIT_LAST;
                    idx_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    data_d = {rx_sync, data_q[7:1]};
                    cnt_d  = BIT_LAST;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ready_d = 1'b1;
                    state_d = RX_WAIT_ACK;
                end
            end
            RX_WAIT_ACK: begin
                if (!rx_go) begin
                    ready_d = 1'b0;
                    state_d = RX_WAIT_GO;
                end
            end
            RX_WAIT_GO: begin
                if (rx_go && rx_sync) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data       = data_q;
    assign rx_data_ready = ready_q;
endmodule

// File: rtl/uart_link.sv
// 8N1 UART transceiver: inline transmitter plus the uart_link_rx receiver.
// state         | meaning
// TX_IDLE       | line high, waiting for tx_go
// TX_START      | start bit (0) on the line
// TX_DATA       | 8 data bits, LSB first
// TX_STOP       | stop bit (1); tx_bsy drops when it ends
// TX_WAIT_GO_LOW| frame done, waiting for tx_go to drop
module uart_link #(
    parameter int ClockFrequencyHz = 20_250_000,
    parameter int BaudRate         = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       uart_tx,
    input  logic [7:0] tx_data,
    input  logic       tx_go,
    output logic       tx_bsy,
    input  logic       uart_rx,
    input  logic       rx_go,
    output logic [7:0] rx_data,
    output logic       rx_data_ready
);
    localparam int BitTime = ClockFrequencyHz / BaudRate;
    localparam int CW = $clog2(BitTime + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BitTime - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT_GO_LOW
    } tx_state_t;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          line_q, line_d;
    logic          bsy_q, bsy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
            bsy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            line_q  <= line_d;
            bsy_q   <= bsy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        line_d  = line_q;
        bsy_d   = bsy_q;
        case (state_q)
            TX_IDLE: begin
                if (tx_go) begin
                    sh_d    = tx_data;
                    line_d  = 1'b0;
                    bsy_d   = 1'b1;
                    cnt_d   = BIT_LAST;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    line_d  = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    idx_d   = '0;
                    cnt_d   = BIT_LAST;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = BIT_LAST;
                    if (idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        line_d = sh_q[0];
                        sh_d   = {1'b0, sh_q[7:1]};
                        idx_d  = idx_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    bsy_d   = 1'b0;
                    state_d = TX_WAIT_GO_LOW;
                end
            end
            TX_WAIT_GO_LOW: begin
                if (!tx_go) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign uart_tx = line_q;
    assign tx_bsy  = bsy_q;

    uart_link_rx #(.BitTime(BitTime)) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .rx_go         (rx_go),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready)
    );
endmodule

// File: tb/tb_uart_link.sv
// Self-checking bench for uart_link at BitTime = 10 cycles.
module tb_uart_link;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_go = 1'b0;
    logic       tx_bsy;
    logic       uart_rx;
    logic       rx_go = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       loopback = 1'b0;
    logic       tb_rx = 1'b1;
    logic [7:0] rx_expect = 8'h00;

    int errors = 0;
    int checks = 0;

    assign uart_rx = loopback ? uart_tx : tb_rx;

    always #5 clk = ~clk;

    uart_link #(.ClockFrequencyHz(1_000_000), .BaudRate(100_000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_tx       (uart_tx),
        .tx_data       (tx_data),
        .tx_go         (tx_go),
        .tx_bsy        (tx_bsy),
        .uart_rx       (uart_rx),
        .rx_go         (rx_go),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmit model: a frame is 100 cycles counted from the accepting edge.
    bit         m_active = 1'b0;
    bit         m_armed  = 1'b1;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_armed  <= 1'b1;
            m_t      <= 0;
        end else if (m_active) begin
            m_t <= m_t + 1;
            if (m_t == 99) m_active <= 1'b0;
        end else if (!m_armed) begin
            if (!tx_go) m_armed <= 1'b1;
        end else if (tx_go) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_byte   <= tx_data;
            m_armed  <= 1'b0;
        end
    end

    function automatic logic exp_line();
        if (!m_active) return 1'b1;
        if (m_t < 10) return 1'b0;
        if (m_t >= 90) return 1'b1;
        return m_byte[(m_t - 10) / 10];
    endfunction

    always @(negedge clk) begin
        check("tx_line", {31'd0, uart_tx}, {31'd0, exp_line()});
        check("tx_bsy", {31'd0, tx_bsy}, {31'd0, m_active});
        if (rx_data_ready) check("rx_data", {24'd0, rx_data}, {24'd0, rx_expect});
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tb_rx = frame[i];
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] vec;
        int bsy_cnt, frames, lat, drops, nrecv;
        logic prev, seen;
        logic [7:0] got [2];

        got[0] = 8'h00;
        got[1] = 8'h00;
        vec = '0;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_tx_bsy", {31'd0, tx_bsy}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_data_ready}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0xA5 from a one-cycle pulse.
        tx_data = 8'hA5;
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        bsy_cnt = 0;
        for (int t = 0; t < 120; t++) begin
            if (t < 100 && t % 10 == 5) vec[t / 10] = uart_tx;
            if (tx_bsy) bsy_cnt++;
            @(negedge clk);
        end
        check("tx_a5_bits", {22'd0, vec}, {22'd0, 10'b1101001010});
        check("tx_a5_bsy_cycles", bsy_cnt, 32'd100);

        // Held tx_go yields one frame only.
        tx_data = 8'h5A;
        tx_go = 1'b1;
        frames = 0;
        prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_bsy && !prev) frames++;
            prev = tx_bsy;
        end
        check("tx_held_frames", frames, 32'd1);
        tx_go = 1'b0;
        repeat (3) @(negedge clk);
        tx_go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_bsy) seen = 1'b1;
        end
        check("tx_rearm_start", {31'd0, seen}, 32'd1);
        tx_go = 1'b0;
        for (int i = 0; i < 120 && tx_bsy; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        // Loopback 0x3C.
        loopback = 1'b1;
        rx_go = 1'b1;
        rx_expect = 8'h3C;
        repeat (2) @(negedge clk);
        tx_data = 8'h3C;
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        lat = -1;
        for (int k = 0; k <= 150; k++) begin
            if (rx_data_ready) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("rx_latency_in_bound", {31'd0, (lat >= 90 && lat <= 97)}, 32'd1);
        check("rx_byte_3c", {24'd0, rx_data}, 32'h3C);
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rx_data_ready) drops++;
        end
        check("rx_ready_held", drops, 32'd0);
        rx_go = 1'b0;
        @(negedge clk);
        check("rx_ack_clears", {31'd0, rx_data_ready}, 32'd0);
        loopback = 1'b0;
        rx_go = 1'b1;
        repeat (5) @(negedge clk);

        // Back-to-back 0x41, 0x42 with no idle gap.
        rx_expect = 8'h41;
        nrecv = 0;
        fork
            begin
                send_byte(8'h41);
                send_byte(8'h42);
                repeat (5) @(negedge clk);
            end
            begin
                for (int n = 0; n < 2; n++) begin
                    seen = 1'b0;
                    for (int c = 0; c < 300; c++) begin
                        @(negedge clk);
                        if (rx_data_ready) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    if (seen) begin
                        got[n] = rx_data;
                        nrecv++;
                    end
                    rx_go = 1'b0;
                    @(negedge clk);
                    rx_expect = 8'h42;
                    rx_go = 1'b1;
                end
            end
        join
        check("rx_b2b_count", nrecv, 32'd2);
        check("rx_b2b_first", {24'd0, got[0]}, 32'h41);
        check("rx_b2b_second", {24'd0, got[1]}, 32'h42);
        repeat (5) @(negedge clk);

        // Short low pulse is rejected; receiver still works afterwards.
        rx_expect = 8'h96;
        tb_rx = 1'b0;
        repeat (3) @(negedge clk);
        tb_rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (rx_data_ready) seen = 1'b1;
        end
        check("rx_glitch_no_ready", {31'd0, seen}, 32'd0);
        send_byte(8'h96);
        check("rx_after_glitch_ready", {31'd0, rx_data_ready}, 32'd1);
        check("rx_after_glitch_byte", {24'd0, rx_data}, 32'h96);
        rx_go = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame aborts immediately.
        tx_data = 8'h00;
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        repeat (35) @(negedge clk);
        check("pre_rst_tx_line", {31'd0, uart_tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_line", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_tx_bsy", {31'd0, tx_bsy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
